// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants for the CP0 exception controller: CP0 register
// addresses, ExcCode values, FSM state encodings and the interrupt-pending
// helper used by the top level.
package cp0_exc_ctrl_pkg;

    // CP0 register numbers written through the single CP0 write port
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // ExcCode values (CAUSE[6:2])
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;
    localparam logic [4:0] EXC_TR  = 5'd13;

    // STATUS.EXL bit mask
    localparam logic [31:0] STATUS_EXL_MASK = 32'h0000_0002;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_W_EPC  = 3'd1;
    localparam logic [2:0] ST_W_STAT = 3'd2;
    localparam logic [2:0] ST_REDIR  = 3'd3;
    localparam logic [2:0] ST_W_ERET = 3'd4;

    // Interrupt pending: IE=1, EXL=0 and at least one unmasked IP bit
    function automatic logic int_pending(input logic [31:0] status,
                                         input logic [31:0] cause);
        return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_int_sync.sv
// Per-bit multi-flop synchroniser for the raw external interrupt lines.
// Each bit gets its own STAGES-deep shift chain; reset is asynchronous,
// active-low, and clears every stage.
module cp0_exc_ctrl_int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [STAGES-1:0] chain_reg;

            // Shift the raw level through the synchroniser chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[STAGES-2:0], async_in[gi]};
                end
            end

            assign sync_out[gi] = chain_reg[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: synchronises interrupt sources, arbitrates
// interrupts / MEM-stage exceptions / ERET, and sequences the EPC and
// STATUS updates through CP0's single write port before flushing and
// redirecting the pipeline.
// Optional feature macro: CP0_IV_VECTOR_EN -- when defined, interrupts
// taken with cause_i[23]=1 redirect to INT_VECTOR instead of EXC_VECTOR.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] INT_VECTOR  = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_src_i,
    input  logic        timer_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_i,
    input  logic        bd_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic        eret_i,
    output logic [5:0]  int_o,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_wdata_o,
    output logic        exc_cap_o,
    output logic [4:0]  exc_code_o,
    output logic        exc_bd_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    logic [5:0]  sync_int;
    logic        int_pend;
    logic        idle;
    logic        take_int;
    logic        take_exc;
    logic        take_eret;
    logic [31:0] int_target;
    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [31:0] pc_reg;
    logic [31:0] target_reg;

    // CAUSE bits outside IP/IV and the unused vector are deliberately ignored
    logic unused_bits;
    assign unused_bits = ^{cause_i[31:24], cause_i[22:16], cause_i[7:0], INT_VECTOR};

    cp0_exc_ctrl_int_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (int_src_i),
        .sync_out (sync_int)
    );

    // Timer interrupt shares line 5; gated so every output reads 0 in reset
    assign int_o = {sync_int[5] | (timer_int_i & rst), sync_int[4:0]};

    // Request arbitration in IDLE: interrupt > exception > ERET
    always_comb begin
        int_pend  = int_pending(status_i, cause_i);
        idle      = (state_reg == ST_IDLE) & rst;
        take_int  = idle & int_pend & pc_valid_i;
        take_exc  = idle & ~take_int & exc_valid_i;
        take_eret = idle & ~take_int & ~exc_valid_i & eret_i;
`ifdef CP0_IV_VECTOR_EN
        int_target = cause_i[23] ? INT_VECTOR : EXC_VECTOR;
`else
        int_target = EXC_VECTOR;
`endif
    end

    // Next-state logic for the entry / ERET sequences
    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE: begin
                if (take_int || take_exc) begin
                    state_next = ST_W_EPC;
                end else if (take_eret) begin
                    state_next = ST_W_ERET;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_W_EPC:  state_next = ST_W_STAT;
            ST_W_STAT: state_next = ST_REDIR;
            ST_W_ERET: state_next = ST_REDIR;
            ST_REDIR:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and request capture (pc, bd, code, redirect target)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            target_reg <= '0;
            exc_code_o <= '0;
            exc_bd_o   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (take_int || take_exc) begin
                pc_reg     <= pc_i;
                exc_bd_o   <= bd_i;
                exc_code_o <= take_int ? EXC_INT : exc_code_i;
                target_reg <= take_int ? int_target : EXC_VECTOR;
            end else if (take_eret) begin
                target_reg <= epc_i;
            end
        end
    end

    // Output decode: CP0 writes, capture strobe, flush and stall
    always_comb begin
        cp0_we_o    = 1'b0;
        cp0_waddr_o = '0;
        cp0_wdata_o = '0;
        exc_cap_o   = 1'b0;
        flush_o     = 1'b0;
        new_pc_o    = '0;
        stall_o     = (state_reg != ST_IDLE) | take_int | take_exc | take_eret;
        case (state_reg)
            ST_W_EPC: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = CP0_REG_EPC;
                // Delay-slot faults restart at the branch (wraps mod 2^32)
                cp0_wdata_o = exc_bd_o ? (pc_reg - 32'd4) : pc_reg;
            end
            ST_W_STAT: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = CP0_REG_STATUS;
                cp0_wdata_o = status_i | STATUS_EXL_MASK;
                exc_cap_o   = 1'b1;
            end
            ST_W_ERET: begin
                cp0_we_o    = 1'b1;
                cp0_waddr_o = CP0_REG_STATUS;
                cp0_wdata_o = status_i & ~STATUS_EXL_MASK;
            end
            ST_REDIR: begin
                flush_o  = 1'b1;
                new_pc_o = target_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: stimulus pushes expected CP0 writes
// and flushes (with the cycle they must appear in); a negedge monitor pops
// and compares whenever the DUT writes CP0 or flushes.
module tb_cp0_exc_ctrl;
    import cp0_exc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  int_src_i = '0;
    logic        timer_int_i = 1'b0;
    logic [31:0] status_i = '0;
    logic [31:0] cause_i = '0;
    logic [31:0] epc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        bd_i = 1'b0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic        eret_i = 1'b0;
    logic [5:0]  int_o;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_wdata_o;
    logic        exc_cap_o;
    logic [4:0]  exc_code_o;
    logic        exc_bd_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    typedef struct {
        int          cyc;
        logic        is_flush;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        cap;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

`ifdef CP0_IV_VECTOR_EN
    localparam logic [31:0] IV_TARGET = 32'h0000_0040;
`else
    localparam logic [31:0] IV_TARGET = 32'h0000_0020;
`endif

    cp0_exc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .int_src_i   (int_src_i),
        .timer_int_i (timer_int_i),
        .status_i    (status_i),
        .cause_i     (cause_i),
        .epc_i       (epc_i),
        .pc_valid_i  (pc_valid_i),
        .pc_i        (pc_i),
        .bd_i        (bd_i),
        .exc_valid_i (exc_valid_i),
        .exc_code_i  (exc_code_i),
        .eret_i      (eret_i),
        .int_o       (int_o),
        .cp0_we_o    (cp0_we_o),
        .cp0_waddr_o (cp0_waddr_o),
        .cp0_wdata_o (cp0_wdata_o),
        .exc_cap_o   (exc_cap_o),
        .exc_code_o  (exc_code_o),
        .exc_bd_o    (exc_bd_o),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .new_pc_o    (new_pc_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_valid_i  = 1'b0;
        exc_valid_i = 1'b0;
        eret_i      = 1'b0;
        bd_i        = 1'b0;
    endtask

    task automatic push_exc(input int c, input logic [31:0] epc_val,
                            input logic [31:0] stat_val, input logic [31:0] target);
        sbq.push_back('{cyc: c + 1, is_flush: 1'b0, addr: 5'd14, data: epc_val, cap: 1'b0});
        sbq.push_back('{cyc: c + 2, is_flush: 1'b0, addr: 5'd12, data: stat_val, cap: 1'b1});
        sbq.push_back('{cyc: c + 3, is_flush: 1'b1, addr: 5'd0, data: target, cap: 1'b0});
    endtask

    task automatic issue(input logic v, input logic ex, input logic er,
                         input logic [31:0] pc, input logic b, input logic [4:0] code);
        pc_valid_i  = v;
        exc_valid_i = ex;
        eret_i      = er;
        pc_i        = pc;
        bd_i        = b;
        exc_code_i  = code;
        #1;
        check("stall_on_accept", stall_o, 1);
        tick();
        idle_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, cp0_we_o, 0);
        check({tag, "_waddr"}, cp0_waddr_o, 0);
        check({tag, "_wdata"}, cp0_wdata_o, 0);
        check({tag, "_cap"}, exc_cap_o, 0);
        check({tag, "_code"}, exc_code_o, 0);
        check({tag, "_bd"}, exc_bd_o, 0);
        check({tag, "_stall"}, stall_o, 0);
        check({tag, "_flush"}, flush_o, 0);
        check({tag, "_newpc"}, new_pc_o, 0);
        check({tag, "_int"}, int_o, 0);
    endtask

    // Monitor: every CP0 write or flush must match the next expected item
    always @(negedge clk) begin
        exp_t e;
        if (rst && (cp0_we_o || flush_o)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: cycle %0d we=%0b addr=%0d data=%h flush=%0b pc=%h, required no output",
                         cyc, cp0_we_o, cp0_waddr_o, cp0_wdata_o, flush_o, new_pc_o);
            end else begin
                e = sbq.pop_front();
                check("event_cycle", cyc, e.cyc);
                if (e.is_flush) begin
                    check("flush", flush_o, 1);
                    check("new_pc", new_pc_o, e.data);
                    check("stall_at_flush", stall_o, 1);
                    check("we_at_flush", cp0_we_o, 0);
                    $display("cycle %0d: flush new_pc=%h", cyc, new_pc_o);
                end else begin
                    check("we", cp0_we_o, 1);
                    check("waddr", cp0_waddr_o, e.addr);
                    check("wdata", cp0_wdata_o, e.data);
                    check("exc_cap", exc_cap_o, e.cap);
                    check("stall_in_write", stall_o, 1);
                    $display("cycle %0d: cp0 write addr=%0d data=%h cap=%0b",
                             cyc, cp0_waddr_o, cp0_wdata_o, exc_cap_o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state
        #2;
        check_all_zero("reset");
        tick(); tick();
        rst = 1'b1;
        tick();

        // Timer interrupt folds into int_o[5] combinationally
        timer_int_i = 1'b1;
        #1;
        check("timer_int", int_o, 6'b100000);
        timer_int_i = 1'b0;
        tick();

        // Interrupt pending while MEM holds a bubble: must wait
        status_i  = 32'h1000_0401;
        cause_i   = 32'h0000_0400;
        int_src_i = 6'b000100;
        #1;
        check("int_sync_0", int_o, 6'b000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("int_wait_stall", stall_o, 0);
            check("int_sync", int_o, (i == 0) ? 6'b000000 : 6'b000100);
        end
        c = cyc;
        push_exc(c, 32'h0000_0100, 32'h1000_0403, 32'h0000_0020);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 5'd0);
        check("int_code", exc_code_o, 0);
        tick(); tick(); tick();
        cause_i   = 32'h0;
        int_src_i = 6'b0;
        check("idle_after_int", stall_o, 0);

        // Syscall in a delay slot
        status_i = 32'h1000_0000;
        c = cyc;
        push_exc(c, 32'h0000_0200, 32'h1000_0002, 32'h0000_0020);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0204, 1'b1, EXC_SYS);
        check("sys_code", exc_code_o, 8);
        check("sys_bd", exc_bd_o, 1);
        tick(); tick(); tick();

        // ERET: clear EXL, return to EPC two cycles after request
        status_i = 32'h1000_0003;
        epc_i    = 32'h0000_0300;
        c = cyc;
        sbq.push_back('{cyc: c + 1, is_flush: 1'b0, addr: 5'd12, data: 32'h1000_0001, cap: 1'b0});
        sbq.push_back('{cyc: c + 2, is_flush: 1'b1, addr: 5'd0, data: 32'h0000_0300, cap: 1'b0});
        issue(1'b1, 1'b0, 1'b1, 32'h0000_0280, 1'b0, 5'd0);
        tick(); tick();
        check("idle_after_eret", stall_o, 0);

        // Faulting ERET: exception wins
        status_i = 32'h1000_0000;
        c = cyc;
        push_exc(c, 32'h0000_0400, 32'h1000_0002, 32'h0000_0020);
        issue(1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0, EXC_RI);
        check("ri_code", exc_code_o, 10);
        check("ri_bd", exc_bd_o, 0);
        tick(); tick(); tick();

        // pc-4 wraps when a delay-slot instruction sits at address 0
        c = cyc;
        push_exc(c, 32'hFFFF_FFFC, 32'h1000_0002, 32'h0000_0020);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, EXC_OV);
        check("ov_code", exc_code_o, 12);
        tick(); tick(); tick();

        // Interrupt with IV set: vector depends on build option
        status_i = 32'h1000_0401;
        cause_i  = 32'h0080_0400;
        c = cyc;
        push_exc(c, 32'h0000_0500, 32'h1000_0403, IV_TARGET);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0500, 1'b0, 5'd0);
        check("iv_code", exc_code_o, 0);
        tick(); tick(); tick();
        cause_i  = 32'h0;
        status_i = 32'h1000_0000;

        // Reset lands in W_STAT: outputs clear at once, no flush follows
        c = cyc;
        sbq.push_back('{cyc: c + 1, is_flush: 1'b0, addr: 5'd14, data: 32'h0000_0600, cap: 1'b0});
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0600, 1'b0, EXC_TR);
        check("tr_code", exc_code_o, 13);
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("idle_after_reset", stall_o, 0);

        check("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
